// File: rtl/booth4_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
//   state_e  : control FSM states
//   op_e     : partial-product selection applied by the datapath each iteration
//   booth_op : maps the Booth triplet {Q[1], Q[0], Q[-1]} to a partial-product op
package booth4_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_M = 3'd2,
        LOAD_Q = 3'd3,
        ITER   = 3'd4,
        DONE   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_ZERO   = 3'd0,
        OP_ADD_M  = 3'd1,
        OP_ADD_2M = 3'd2,
        OP_SUB_M  = 3'd3,
        OP_SUB_2M = 3'd4
    } op_e;

    function automatic op_e booth_op(input logic [2:0] trip);
        op_e op;
        case (trip)
            3'b000, 3'b111: op = OP_ZERO;
            3'b001, 3'b010: op = OP_ADD_M;
            3'b011:         op = OP_ADD_2M;
            3'b100:         op = OP_SUB_2M;
            3'b101, 3'b110: op = OP_SUB_M;
            default:        op = OP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth4_datapath.sv
// Registers, adder and shifter of the radix-4 Booth multiplier.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : zero A and Q[-1], preload the iteration count
//   load_m, load_q : capture data_in into M / Q
//   step           : perform one Booth iteration using op
//   op             : partial-product selection for this iteration
//   data_in        : shared operand bus
//   triplet        : {Q[1], Q[0], Q[-1]} for the Booth decoder
//   last_iter      : the current iteration is the final one
//   product        : {A[WIDTH-1:0], Q}
module booth4_datapath
    import booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load_m,
    input  logic                 load_q,
    input  logic                 step,
    input  op_e                  op,
    input  logic [WIDTH-1:0]     data_in,
    output logic [2:0]           triplet,
    output logic                 last_iter,
    output logic [2*WIDTH-1:0]   product
);

    localparam int AW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH / 2) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    A_ZERO   = {AW{1'b0}};

    logic [AW-1:0]      a_r;
    logic [WIDTH-1:0]   m_r;
    logic [WIDTH-1:0]   q_r;
    logic               qm1_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [AW-1:0]      m_ext_s;
    logic [AW-1:0]      pp_s;
    logic [AW-1:0]      sum_s;
    logic [2*WIDTH+2:0] wide_s;
    logic [2*WIDTH+2:0] shifted_s;

    // Two guard bits on M keep +/-2M representable in the accumulator.
    assign m_ext_s = {{2{m_r[WIDTH-1]}}, m_r};

    // Partial-product selection from the decoded Booth op.
    always_comb begin
        pp_s = A_ZERO;
        case (op)
            OP_ZERO:   pp_s = A_ZERO;
            OP_ADD_M:  pp_s = m_ext_s;
            OP_ADD_2M: pp_s = {m_ext_s[AW-2:0], 1'b0};
            OP_SUB_M:  pp_s = A_ZERO - m_ext_s;
            OP_SUB_2M: pp_s = A_ZERO - {m_ext_s[AW-2:0], 1'b0};
            default:   pp_s = A_ZERO;
        endcase
    end

    // Add, then arithmetic shift of {T, Q, Q[-1]} right by two.
    assign sum_s     = a_r + pp_s;
    assign wide_s    = {sum_s, q_r, qm1_r};
    assign shifted_s = {{2{sum_s[AW-1]}}, wide_s[2*WIDTH+2:2]};

    // Datapath register updates; the control never asserts two strobes at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= A_ZERO;
            m_r   <= {WIDTH{1'b0}};
            q_r   <= {WIDTH{1'b0}};
            qm1_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            a_r   <= A_ZERO;
            qm1_r <= 1'b0;
            cnt_r <= CNT_INIT;
        end else if (load_m) begin
            m_r <= data_in;
        end else if (load_q) begin
            q_r <= data_in;
        end else if (step) begin
            a_r   <= shifted_s[2*WIDTH+2:WIDTH+1];
            q_r   <= shifted_s[WIDTH:1];
            qm1_r <= shifted_s[0];
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    assign triplet   = {q_r[1:0], qm1_r};
    // Count reaches zero after this step when it currently holds one.
    assign last_iter = (cnt_r == CNT_ONE);
    assign product   = {a_r[WIDTH-1:0], q_r};

endmodule

// File: rtl/booth4_multiplier.sv
// Sequential signed radix-4 (modified Booth) multiplier.
// Operands arrive serially on data_in: multiplicand, then multiplier.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset, aborts any operation
//   start   : request a multiplication (sampled in IDLE and DONE)
//   data_in : shared operand bus, two's complement
//   out     : signed product {A[WIDTH-1:0], Q}, valid while done=1
//   done    : product valid
module booth4_multiplier
    import booth4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [2*WIDTH-1:0] out,
    output logic               done
);

    state_e     state_r;
    state_e     next_state_s;
    logic       done_r;
    logic       clear_s;
    logic       load_m_s;
    logic       load_q_s;
    logic       step_s;
    logic [2:0] triplet_s;
    logic       last_iter_s;
    op_e        op_s;

    assign op_s = booth_op(triplet_s);

    // Next-state and datapath strobe decode.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        load_m_s     = 1'b0;
        load_q_s     = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CLEAR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: begin
                clear_s      = 1'b1;
                next_state_s = LOAD_M;
            end
            LOAD_M: begin
                load_m_s     = 1'b1;
                next_state_s = LOAD_Q;
            end
            LOAD_Q: begin
                load_q_s     = 1'b1;
                next_state_s = ITER;
            end
            ITER: begin
                step_s = 1'b1;
                if (last_iter_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ITER;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register; done is registered alongside so it tracks DONE exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= (next_state_s == DONE);
        end
    end

    assign done = done_r;

    booth4_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .load_m    (load_m_s),
        .load_q    (load_q_s),
        .step      (step_s),
        .op        (op_s),
        .data_in   (data_in),
        .triplet   (triplet_s),
        .last_iter (last_iter_s),
        .product   (out)
    );

endmodule

// File: tb/tb_booth4_multiplier.sv
module tb_booth4_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   data_in;
    logic [2*W-1:0] out;
    logic           done;

    int checks   = 0;
    int failures = 0;
    int ops_done = 0;
    int rises    = 0;
    logic prev_done = 1'b0;

    booth4_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .out     (out),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Count rising edges of done, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done === 1'b0) rises++;
        prev_done = done;
    end

    // Golden model: plain signed multiplication.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, obs, expv);
        end
    endtask

    task automatic check_word(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Full operation from IDLE/DONE; leaves start high and the FSM in DONE.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input string tag);
        int edges;
        logic [2*W-1:0] expv;
        expv    = model(m, q);
        start   = 1'b1;
        data_in = W'($urandom);
        @(negedge clk);           // start sampled (edge 1)
        @(negedge clk);           // CLEAR done (edge 2 next loads M)
        data_in = m;
        @(negedge clk);
        data_in = q;
        @(negedge clk);           // 3 edges after start sampled
        data_in = W'($urandom);
        edges = 3;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        assert (edges == 3 + W / 2) else begin
            failures++;
            $error("FAIL %s_latency got=%0d exp=%0d", tag, edges, 3 + W / 2);
        end
        check_word({tag, "_out"}, out, expv);
        ops_done++;
    endtask

    task automatic release_start(input string tag);
        start = 1'b0;
        @(negedge clk);
        check_bit({tag, "_done_low"}, done, 1'b0);
    endtask

    initial begin
        logic [2*W-1:0] held;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = {W{1'b0}};
        repeat (2) @(negedge clk);
        check_word("reset_out", out, {2*W{1'b0}});
        check_bit("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including signed extremes.
        run_op(16'hFFF3, 16'h0019, "neg13x25");
        check_word("neg13x25_const", out, 32'hFFFF_FEBB);
        release_start("neg13x25");
        run_op(16'h7FFF, 16'h7FFF, "maxpos");   release_start("maxpos");
        run_op(16'h8000, 16'h8000, "maxneg");
        check_word("maxneg_const", out, 32'h4000_0000);
        release_start("maxneg");
        run_op(16'h8000, 16'h7FFF, "mixed");    release_start("mixed");
        run_op(16'h0000, 16'h1234, "zero");     release_start("zero");
        run_op(16'hFFFF, 16'h0001, "m1x1");     release_start("m1x1");
        run_op(16'hFFFF, 16'hFFFF, "m1xm1");

        // Holding start keeps DONE and a stable product.
        held = out;
        repeat (3) @(negedge clk);
        check_bit("hold_done", done, 1'b1);
        check_word("hold_out", out, held);
        release_start("hold");
        run_op(16'd3, 16'd5, "3x5");
        check_word("3x5_const", out, 32'd15);
        release_start("3x5");

        // Reset in the middle of ITER aborts the operation.
        start   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        data_in = 16'h1357;
        @(negedge clk);
        data_in = 16'h2468;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_bit("abort_done", done, 1'b0);
        check_word("abort_out", out, {2*W{1'b0}});
        rst = 1'b0;
        run_op(16'hFFF9, 16'hFFF7, "m7xm9");
        check_word("m7xm9_const", out, 32'd63);
        release_start("m7xm9");

        // Randomized operand pairs.
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), "rand");
            release_start("rand");
        end

        check_word("done_rises", 32'(rises), 32'(ops_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
